// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// legal byte-lane write masks and the latency counter width.
package dmem_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_B0   = 4'b0001;
  localparam logic [3:0] WEN_B1   = 4'b0010;
  localparam logic [3:0] WEN_B2   = 4'b0100;
  localparam logic [3:0] WEN_B3   = 4'b1000;
  localparam logic [3:0] WEN_H0   = 4'b0011;
  localparam logic [3:0] WEN_H1   = 4'b0110;
  localparam logic [3:0] WEN_H2   = 4'b1100;
  localparam logic [3:0] WEN_W    = 4'b1111;

  function automatic logic wen_legal(input logic [3:0] wen);
    return wen inside {WEN_NONE, WEN_B0, WEN_B1, WEN_B2, WEN_B3,
                       WEN_H0, WEN_H1, WEN_H2, WEN_W};
  endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// Single-port word RAM with byte-lane write enables and read-before-write.
// One-cycle read latency; the read register holds until the next enabled access.
module dmem_bank_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Old word is captured in the same edge that merges the new lanes.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response READ_LAT cycles after accept,
// held until rsp_ready. Optional request checking under DMEM_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 14,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wen,
  input  logic [31:0]       req_wdata,
  input  logic              req_ren,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              rd_keep, rd_keep_nx;
  logic              err_q, err_nx;

  logic [ADDR_W-3:0] word_idx;
  logic [RAM_AW-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_q;
  logic              req_err;
  logic              accept;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];
  assign word_idx        = req_addr[ADDR_W-1:2];
  assign ram_addr        = RAM_AW'(32'(word_idx) % 32'(DEPTH_WORDS));

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = !wen_legal(req_wen) || (32'(word_idx) >= 32'(DEPTH_WORDS));
`else
  assign req_err = 1'b0;
`endif

  assign req_ready = rst && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign ram_we    = (accept && !req_err) ? req_wen : 4'b0000;

  dmem_bank_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_keep <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rd_keep <= rd_keep_nx;
      err_q   <= err_nx;
    end
  end

  // The counter leaves WAIT on the cycle it would decrement to zero so that
  // rsp_valid first rises exactly READ_LAT cycles after acceptance.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    rd_keep_nx = rd_keep;
    err_nx     = err_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_nx     = CNT_W'(READ_LAT - 1);
          rd_keep_nx = req_ren && !req_err;
          err_nx     = req_err;
          state_nx   = (READ_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The RAM read register is untouched until the next acceptance, so it
  // doubles as the held response data.
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (rsp_valid && rd_keep) ? ram_q : 32'h0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a word/lane memory model checked every cycle plus
// directed transactions with literal expected results.
module tb_dmem_responder;

  localparam int DEPTH    = 4096;
  localparam int AW       = 15;
  localparam int READ_LAT = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_wen;
  logic [31:0]   req_wdata;
  logic          req_ren;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (AW),
    .READ_LAT    (READ_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_ren   (req_ren),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mval  [int];
  logic [3:0]  mmask [int];
  bit          m_pending = 1'b0;
  int          m_due     = 0;
  logic [31:0] m_rdata   = '0;
  bit          m_known   = 1'b0;
  logic        m_err     = 1'b0;

  always @(negedge clk) begin : model_cmp
    bit          exp_ready, exp_valid;
    int          w;
    logic        e;
    logic [31:0] v;
    logic [3:0]  m;

    exp_ready = rst && !m_pending;
    exp_valid = rst && m_pending && (cyc >= m_due);
    chk1("m_req_ready", req_ready, exp_ready);
    chk1("m_rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) begin
      if (m_known) chk("m_rsp_rdata", rsp_rdata, m_rdata);
      chk1("m_rsp_err", rsp_err, m_err);
    end
    if (!rst) begin
      chk("m_rst_rdata", rsp_rdata, 32'h0);
      chk1("m_rst_err", rsp_err, 1'b0);
      m_pending = 1'b0;
    end else if (exp_ready && req_valid) begin
      w = int'(req_addr[AW-1:2]);
`ifdef DMEM_ERR_CHECK_EN
      e = !(req_wen inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0011, 4'b0110, 4'b1100, 4'b1111}) || (w >= DEPTH);
`else
      e = 1'b0;
      w = w % DEPTH;
`endif
      m_rdata = 32'h0;
      m_known = 1'b1;
      m_err   = e;
      if (req_ren && !e) begin
        if (mmask.exists(w) && mmask[w] == 4'hF) m_rdata = mval[w];
        else m_known = 1'b0;
      end
      if (!e && req_wen != 4'b0000) begin
        v = mval.exists(w) ? mval[w] : 32'h0;
        m = mmask.exists(w) ? mmask[w] : 4'h0;
        for (int i = 0; i < 4; i++) begin
          if (req_wen[i]) begin
            v[8*i +: 8] = req_wdata[8*i +: 8];
            m[i] = 1'b1;
          end
        end
        mval[w]  = v;
        mmask[w] = m;
      end
      m_pending = 1'b1;
      m_due     = cyc + READ_LAT;
    end else if (exp_valid && rsp_ready) begin
      m_pending = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [AW-1:0] a, input logic [3:0] w,
                       input logic [31:0] d, input logic r);
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    req_ren   = r;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(output int t);
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        t = cyc;
        break;
      end
    end
    total++;
    if (t < 0) begin
      bad++;
      $display("FAIL accept_timeout got=none want=accept (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hA5A5A5A5;
    req_wen   = 4'b1111;
  endtask

  task automatic wait_rsp(output int t, output logic [31:0] d, output logic e);
    t = -1;
    d = 32'h0;
    e = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        t = cyc;
        d = rsp_rdata;
        e = rsp_err;
        break;
      end
    end
    total++;
    if (t < 0) begin
      bad++;
      $display("FAIL rsp_timeout got=none want=rsp_valid (cycle %0d)", cyc);
    end
  endtask

  task automatic txn(input logic [AW-1:0] a, input logic [3:0] w, input logic [31:0] d,
                     input logic r, output logic [31:0] rd, output logic er);
    int ta, tr;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drive(a, w, d, r);
    wait_accept(ta);
    wait_rsp(tr, rd, er);
    chk("latency", 32'(tr - ta), 32'(READ_LAT));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] d;
    logic        e;
    int          ta, tr, th;

    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = '0;
    req_wdata = '0; req_ren = 1'b0; rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk1("idle_req_ready", req_ready, 1'b1);

    // SW then LW
    txn(15'h0010, 4'b1111, 32'hDEADBEEF, 1'b0, d, e);
    chk("sw_rdata", d, 32'h0);
    chk1("sw_err", e, 1'b0);
    txn(15'h0010, 4'b0000, 32'h0, 1'b1, d, e);
    chk("lw_rdata", d, 32'hDEADBEEF);
    chk1("lw_err", e, 1'b0);

    // SB / SH merges
    txn(15'h0012, 4'b0100, 32'h00AA0000, 1'b0, d, e);
    txn(15'h0010, 4'b0000, 32'h0, 1'b1, d, e);
    chk("sb_merge", d, 32'hDEAABEEF);
    txn(15'h0010, 4'b0011, 32'h00001234, 1'b0, d, e);
    txn(15'h0013, 4'b0000, 32'h0, 1'b1, d, e);
    chk("sh_merge", d, 32'hDEAA1234);

    // Read-before-write
    txn(15'h0020, 4'b1111, 32'h11111111, 1'b0, d, e);
    txn(15'h0020, 4'b1111, 32'h22222222, 1'b1, d, e);
    chk("rbw_old", d, 32'h11111111);
    txn(15'h0020, 4'b0000, 32'h0, 1'b1, d, e);
    chk("rbw_new", d, 32'h22222222);

    // Empty request
    txn(15'h0020, 4'b0000, 32'hFFFFFFFF, 1'b0, d, e);
    chk("nop_rdata", d, 32'h0);
    chk1("nop_err", e, 1'b0);

    // Backpressure with a second request waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(15'h0010, 4'b0000, 32'h0, 1'b1);
    wait_accept(ta);
    drive(15'h0020, 4'b0000, 32'h0, 1'b1);
    wait_rsp(tr, d, e);
    chk("bp_first_rdata", d, 32'hDEAA1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_rdata", rsp_rdata, 32'hDEAA1234);
      chk1("bp_hold_ready", req_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    th = cyc;
    wait_accept(ta);
    chk("bp_accept_gap", 32'(ta - th), 32'd1);
    wait_rsp(tr, d, e);
    chk("bp_second_rdata", d, 32'h22222222);

    // Illegal lane mask and out-of-range index
    txn(15'h0030, 4'b1111, 32'h33333333, 1'b0, d, e);
    txn(15'h0000, 4'b1111, 32'h01020304, 1'b0, d, e);
    txn(15'h0030, 4'b0101, 32'h55555555, 1'b1, d, e);
`ifdef DMEM_ERR_CHECK_EN
    chk1("badwen_err", e, 1'b1);
    chk("badwen_rdata", d, 32'h0);
    txn(15'h0030, 4'b0000, 32'h0, 1'b1, d, e);
    chk("badwen_kept", d, 32'h33333333);
`else
    chk1("badwen_err", e, 1'b0);
    chk("badwen_rdata", d, 32'h33333333);
    txn(15'h0030, 4'b0000, 32'h0, 1'b1, d, e);
    chk("badwen_written", d, 32'h33553355);
`endif
    txn(15'h4000, 4'b1111, 32'h0BADF00D, 1'b1, d, e);
`ifdef DMEM_ERR_CHECK_EN
    chk1("oob_err", e, 1'b1);
    chk("oob_rdata", d, 32'h0);
    txn(15'h0000, 4'b0000, 32'h0, 1'b1, d, e);
    chk("oob_word0_kept", d, 32'h01020304);
`else
    chk1("wrap_err", e, 1'b0);
    chk("wrap_rdata", d, 32'h01020304);
    txn(15'h0000, 4'b0000, 32'h0, 1'b1, d, e);
    chk("wrap_word0", d, 32'h0BADF00D);
`endif

    // Reset two cycles into the wait
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive(15'h0040, 4'b1111, 32'hCAFEF00D, 1'b0);
    wait_accept(ta);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("midrst_valid", rsp_valid, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("postrst_ready", req_ready, 1'b1);
    chk1("postrst_valid", rsp_valid, 1'b0);
    repeat (6) @(negedge clk);
    txn(15'h0040, 4'b0000, 32'h0, 1'b1, d, e);
    chk("postrst_write_kept", d, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data port. It receives the lane-aligned write data and byte-lane write enables that the core's store path produces, plus load requests. It commits byte-masked writes into a word-organised RAM and returns the raw 32-bit word, which the core's load path then extracts, sign-extends or zero-extends. A valid/ready handshake with configurable read latency lets the core stall on data memory.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words stored.
- ADDR_W, 14: byte-address width; must satisfy 2^(ADDR_W-2) >= DEPTH_WORDS.
- READ_LAT, 1: cycles from request acceptance to response; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2], bits [1:0] ignored.
- req_wen  in  4  byte-lane write enables; bit i writes byte lane i.
- req_wdata  in  32  lane-aligned write data.
- req_ren  in  1  read requested.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  raw word read (pre-write contents).
- rsp_err  out  1  request was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- Acceptance occurs in cycle T when req_valid && req_ready.
- On acceptance:
  - The read of the addressed word is launched.
  - In the same edge, lanes with req_wen[i]=1 are written with req_wdata[8i+7:8i]. Other lanes are preserved.
  - State moves to WAIT, and the latency counter loads READ_LAT-1.
- Read-before-write: when req_ren=1 and req_wen!=0 together, rsp_rdata is the old word.
- WAIT: the counter decrements each cycle. At 0, rsp_valid rises, rsp_rdata and rsp_err are registered, and state moves to RESP. If READ_LAT=1, state goes directly to RESP.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1. Then state returns to IDLE.
- A request with req_ren=0 and req_wen=0 is legal: it returns a response with rsp_rdata = 0 and rsp_err = 0.
- For a write-only request, rsp_rdata = 0.
- Legal req_wen values are 0000, 0001, 0010, 0100, 1000, 0011, 0110, 1100 and 1111. Any other pattern is illegal.
- RAM contents are not reset.

## Timing
- Reset values:
  - req_ready = 1 once state is IDLE; forced 0 while rst = 0.
  - rsp_valid = 0, rsp_rdata = 32'h0, rsp_err = 0; state = IDLE; counter = 0.
- Latency: rsp_valid is first high at T+READ_LAT.
- Throughput: at most one request per READ_LAT+1 cycles when rsp_ready is held high. There is no request/response overlap.
- rsp_ready is ignored when rsp_valid = 0.
- Reset asserted mid-operation:
  - The in-flight response is discarded.
  - A write accepted before reset assertion remains committed.
- Request inputs are sampled only at acceptance and may change afterwards.

## Configuration
- DMEM_ERR_CHECK_EN defined:
  - An illegal req_wen, or a word index >= DEPTH_WORDS, suppresses the write and returns rsp_err = 1 with rsp_rdata = 0.
  - Latency is unchanged.
- Undefined:
  - rsp_err is tied 0.
  - The word index wraps modulo DEPTH_WORDS.
  - Any req_wen pattern is written as given.

## Structure
- Package dmem_pkg holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - WEN_* legal-mask constants.
  - Latency counter width (3 bits).
- Sub-module dmem_bank_ram: single-port synchronous RAM with 4 byte-lane write enables and read-before-write. It is instantiated once.
- The top level contains the FSM, counter, error check and response registers.

## Test plan
- Reset and SW/LW: reset, write addr 0x10, wen 1111, data 0xDEADBEEF, then read addr 0x10. The read response is 0xDEADBEEF with rsp_err = 0, at exactly T+READ_LAT.
- SB/SH merge on word 0x10 (holding 0xDEADBEEF):
  - wen 0100, data 0x00AA0000, then read: 0xDEAABEEF.
  - wen 0011, data 0x00001234, then read: 0xDEAA1234.
- Read-before-write: word 0x20 holds 0x11111111. Send ren=1, wen=1111, data 0x22222222: response 0x11111111. A following read returns 0x22222222.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a second req_valid is not accepted until 1 cycle after rsp_ready.
- Errors (DMEM_ERR_CHECK_EN defined):
  - wen 0101 to 0x30: rsp_err = 1, and a following read of 0x30 returns its old value.
  - Byte address 0x4000 with DEPTH_WORDS=4096: rsp_err = 1.
- Reset mid-WAIT (READ_LAT=4): assert rst at T+2. rsp_valid = 0 and req_ready = 1 after release. The write from cycle T is visible on a later read.
